// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one uart_tx among NUM_REQ byte sources:
// valid/ready capture, one-cycle launch pulse, optional inter-byte gap, stuck-transmitter watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CLKS     = 0,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic                       clk_25mhz,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [8*NUM_REQ-1:0]       i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_Tx_DV,
  output logic [7:0]                 o_Tx_Byte,
  input  logic                       i_Tx_Active,
  input  logic                       i_Tx_Done,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_busy,
  output logic                       o_err,
  input  logic                       i_err_clr
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
  // The counter reads 0 in the first WAIT_DONE cycle, so matching TIMEOUT_CLKS-2 there
  // makes o_err rise exactly TIMEOUT_CLKS clocks after the launch pulse.
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLKS - 2);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [IW-1:0] PTR_LAST = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

  state_t        state, state_next;
  logic [IW-1:0] ptr;
  logic [IW-1:0] winner;
  logic [IW:0]   idx;
  logic          found;
  logic          grant;
  logic          timeout;
  logic [7:0]    sel_byte;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;

  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (IW+1)'(i);
      if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
      if (!found && i_req_valid[idx[IW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_byte = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == IW'(k)) sel_byte = i_req_data[8*k +: 8];
    end
  end

  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    timeout     = 1'b0;
    o_req_ready = '0;
    case (state)
      IDLE: begin
        if (!rst && !i_Tx_Active && found) begin
          grant               = 1'b1;
          o_req_ready[winner] = 1'b1;
          state_next          = LAUNCH;
        end
      end
      LAUNCH: state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (i_Tx_Done) begin
          state_next = (GAP_CLKS > 0) ? GAP : IDLE;
        end else if (to_cnt == TO_LAST) begin
          timeout    = 1'b1;
          state_next = (GAP_CLKS > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      ptr        <= '0;
      o_Tx_DV    <= 1'b0;
      o_Tx_Byte  <= 8'h00;
      o_grant_id <= '0;
      o_err      <= 1'b0;
      to_cnt     <= '0;
      gap_cnt    <= '0;
    end else begin
      o_Tx_DV <= (state_next == LAUNCH);
      if (grant) begin
        o_Tx_Byte  <= sel_byte;
        o_grant_id <= winner;
        ptr        <= (winner == PTR_LAST) ? '0 : winner + 1'b1;
      end
      if (state == LAUNCH)         to_cnt <= '0;
      else if (state == WAIT_DONE) to_cnt <= to_cnt + 1'b1;
      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
      // A timeout in the same cycle as a clear request leaves the flag set.
      if (timeout)        o_err <= 1'b1;
      else if (i_err_clr) o_err <= 1'b0;
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: behavioural uart_tx model plus a scoreboard of
// expected {grant_id, byte} pairs popped on every launch pulse.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int GAP_CLKS     = 3;
  localparam int TIMEOUT_CLKS = 50;
  localparam int TX_CLKS      = 6;

  logic        clk_25mhz    = 1'b0;
  logic        rst          = 1'b1;
  logic [3:0]  req_valid    = 4'b0000;
  logic [31:0] req_data     = 32'h0;
  logic [3:0]  req_ready;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active;
  logic        tx_done      = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err;
  logic        err_clr      = 1'b0;
  logic        model_en     = 1'b1;
  logic        model_active = 1'b0;
  logic        man_active   = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_total = 0;
  int done_total = 0;
  int last_done_cyc = -100;
  int tx_left = 0;
  logic [9:0] sb_q[$];
  logic [9:0] mon_exp;
  logic       prev_dv = 1'b0;
  logic       prev_accept = 1'b0;

  assign tx_active = model_active | man_active;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .GAP_CLKS(GAP_CLKS), .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) dut (
    .clk_25mhz(clk_25mhz), .rst(rst),
    .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
    .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
    .o_grant_id(grant_id), .o_busy(busy), .o_err(err), .i_err_clr(err_clr)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  initial forever begin
    @(posedge clk_25mhz);
    cyc++;
  end

  // uart_tx stand-in: busy for TX_CLKS cycles after a launch, then a one-cycle done pulse.
  initial forever begin
    @(posedge clk_25mhz); #1;
    tx_done = 1'b0;
    if (model_en) begin
      if (tx_dv) begin
        model_active = 1'b1;
        tx_left      = TX_CLKS;
      end else if (model_active) begin
        tx_left--;
        if (tx_left == 0) begin
          model_active  = 1'b0;
          tx_done       = 1'b1;
          last_done_cyc = cyc;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk_25mhz);
    if (tx_done) done_total++;
    if (tx_dv || prev_accept) begin
      checks++;
      if (!tx_dv || prev_dv || !prev_accept) begin
        errors++;
        $display("[TB] FAIL dv_timing: dv=%0b prev_dv=%0b prev_accept=%0b, required dv=1 prev_dv=0 prev_accept=1",
                 tx_dv, prev_dv, prev_accept);
      end
    end
    if (tx_dv) begin
      dv_total++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_underflow: launch of id=%0d byte=%h with nothing expected", grant_id, tx_byte);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({grant_id, tx_byte} !== mon_exp) begin
          errors++;
          $display("[TB] FAIL sb_launch: got id=%0d byte=%h, expected id=%0d byte=%h",
                   grant_id, tx_byte, mon_exp[9:8], mon_exp[7:0]);
        end
      end
    end
    if (req_ready !== 4'b0000) begin
      checks++;
      if (!$onehot(req_ready) || ((req_ready & ~req_valid) != 4'b0000)) begin
        errors++;
        $display("[TB] FAIL ready_onehot: ready=%b valid=%b, required one-hot subset of valid", req_ready, req_valid);
      end
    end
    prev_dv     = tx_dv;
    prev_accept = (|(req_valid & req_ready)) && !rst;
  end

  initial begin
    #(40 * 20000);
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish within 20000 cycles");
    $fatal(1, "[TB] global timeout");
  end

  task automatic do_reset;
    @(posedge clk_25mhz); #1;
    rst = 1'b1;
    @(posedge clk_25mhz); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk_25mhz);
      ok = (busy == 1'b0) && (tx_active == 1'b0) && (sb_q.size() == 0);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s_drain: busy=%0b active=%0b pending=%0d, required idle with 0 pending",
               tag, busy, tx_active, sb_q.size());
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk_25mhz);
    @(negedge clk_25mhz);
    checks++; if (tx_dv !== 1'b0)     begin errors++; $display("[TB] FAIL rst_dv: got %b, expected 0", tx_dv); end
    checks++; if (tx_byte !== 8'h00)  begin errors++; $display("[TB] FAIL rst_byte: got %h, expected 00", tx_byte); end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("[TB] FAIL rst_ready: got %b, expected 0000", req_ready); end
    checks++; if (grant_id !== 2'd0)  begin errors++; $display("[TB] FAIL rst_grant: got %0d, expected 0", grant_id); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL rst_busy: got %b, expected 0", busy); end
    checks++; if (err !== 1'b0)       begin errors++; $display("[TB] FAIL rst_err: got %b, expected 0", err); end
    @(posedge clk_25mhz); #1;
    rst = 1'b0;
  endtask

  task automatic test_single;
    bit seen;
    @(posedge clk_25mhz); #1;
    req_data[7:0] = 8'h30;
    req_valid     = 4'b0001;
    sb_q.push_back({2'd0, 8'h30});
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_25mhz);
      if (req_ready !== 4'b0000) seen = 1'b1;
    end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL t1_ready: got %b, expected 0001", req_ready); end
    @(posedge clk_25mhz); #1;
    req_valid = 4'b0000;
    @(negedge clk_25mhz);
    checks++; if (tx_dv !== 1'b1)    begin errors++; $display("[TB] FAIL t1_dv: got %b, expected 1", tx_dv); end
    checks++; if (tx_byte !== 8'h30) begin errors++; $display("[TB] FAIL t1_byte: got %h, expected 30", tx_byte); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL t1_grant: got %0d, expected 0", grant_id); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("[TB] FAIL t1_busy: got %b, expected 1", busy); end
    @(negedge clk_25mhz);
    checks++; if (tx_dv !== 1'b0)    begin errors++; $display("[TB] FAIL t1_dv_width: got %b, expected 0", tx_dv); end
    drain("t1");
  endtask

  task automatic test_round_robin;
    int n, dv0, done0;
    do_reset;
    req_data  = {8'h44, 8'h43, 8'h42, 8'h41};
    req_valid = 4'b1111;
    sb_q.push_back({2'd0, 8'h41});
    sb_q.push_back({2'd1, 8'h42});
    sb_q.push_back({2'd2, 8'h43});
    sb_q.push_back({2'd3, 8'h44});
    sb_q.push_back({2'd0, 8'h41});
    dv0   = dv_total;
    done0 = done_total;
    n = 0;
    for (int i = 0; i < 300 && n < 5; i++) begin
      @(negedge clk_25mhz);
      if (tx_dv) n++;
    end
    @(posedge clk_25mhz); #1;
    req_valid = 4'b0000;
    drain("t2");
    @(posedge clk_25mhz); #1;
    checks++; if (dv_total - dv0 != 5)     begin errors++; $display("[TB] FAIL t2_dv_count: got %0d, expected 5", dv_total - dv0); end
    checks++; if (done_total - done0 != 5) begin errors++; $display("[TB] FAIL t2_done_count: got %0d, expected 5", done_total - done0); end
  endtask

  task automatic test_pointer_wrap;
    int n;
    do_reset;
    req_data[15:0] = {8'h51, 8'h50};
    req_valid      = 4'b0010;
    sb_q.push_back({2'd1, 8'h51});
    n = 0;
    for (int i = 0; i < 50 && n < 1; i++) begin
      @(negedge clk_25mhz);
      if (tx_dv) n++;
    end
    @(posedge clk_25mhz); #1;
    req_valid = 4'b0011;
    sb_q.push_back({2'd0, 8'h50});
    sb_q.push_back({2'd1, 8'h51});
    for (int i = 0; i < 300 && n < 3; i++) begin
      @(negedge clk_25mhz);
      if (tx_dv) begin
        n++;
        if (n == 2) begin
          checks++;
          if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL t3_wrap_grant: got %0d, expected 0", grant_id); end
        end
      end
    end
    @(posedge clk_25mhz); #1;
    req_valid = 4'b0000;
    checks++; if (n != 3) begin errors++; $display("[TB] FAIL t3_count: got %0d launches, expected 3", n); end
    drain("t3");
  endtask

  task automatic test_timeout;
    bit seen;
    int l;
    model_en = 1'b0;
    @(posedge clk_25mhz); #1;
    req_data[31:24] = 8'h7E;
    req_valid       = 4'b1000;
    sb_q.push_back({2'd3, 8'h7E});
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_25mhz);
      if (tx_dv) seen = 1'b1;
    end
    l = cyc;
    checks++; if (!seen) begin errors++; $display("[TB] FAIL t4_launch: got no launch, expected one"); end
    @(posedge clk_25mhz); #1;
    req_valid = 4'b0000;
    while (cyc < l + TIMEOUT_CLKS - 1) @(negedge clk_25mhz);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL t4_err_early: got %b, expected 0", err); end
    @(negedge clk_25mhz);
    checks++; if (err !== 1'b1)  begin errors++; $display("[TB] FAIL t4_err_set: got %b, expected 1", err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t4_gap_busy: got %b, expected 1", busy); end
    repeat (GAP_CLKS) @(negedge clk_25mhz);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t4_idle: got busy=%b, expected 0", busy); end
    checks++; if (err !== 1'b1)  begin errors++; $display("[TB] FAIL t4_sticky: got %b, expected 1", err); end
    @(posedge clk_25mhz); #1;
    err_clr = 1'b1;
    @(posedge clk_25mhz); #1;
    err_clr = 1'b0;
    @(negedge clk_25mhz);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL t4_clear: got %b, expected 0", err); end
    model_en = 1'b1;
    drain("t4");
  endtask

  task automatic test_reset_midflight;
    bit seen;
    model_en = 1'b0;
    @(posedge clk_25mhz); #1;
    req_data[15:0] = {8'h22, 8'h11};
    req_valid      = 4'b0001;
    sb_q.push_back({2'd0, 8'h11});
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_25mhz);
      if (tx_dv) seen = 1'b1;
    end
    @(posedge clk_25mhz); #1;
    req_valid  = 4'b0000;
    man_active = 1'b1;
    repeat (3) @(posedge clk_25mhz);
    #1;
    req_valid = 4'b0010;
    rst       = 1'b1;
    @(posedge clk_25mhz); #1;
    rst = 1'b0;
    @(negedge clk_25mhz);
    checks++; if (tx_dv !== 1'b0)    begin errors++; $display("[TB] FAIL t5_dv: got %b, expected 0", tx_dv); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL t5_busy: got %b, expected 0", busy); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("[TB] FAIL t5_byte: got %h, expected 00", tx_byte); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL t5_blocked: got %b, expected 0000", req_ready); end
      @(negedge clk_25mhz);
    end
    @(posedge clk_25mhz); #1;
    man_active = 1'b0;
    model_en   = 1'b1;
    sb_q.push_back({2'd1, 8'h22});
    @(negedge clk_25mhz);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL t5_ready: got %b, expected 0010", req_ready); end
    @(posedge clk_25mhz); #1;
    req_valid = 4'b0000;
    drain("t5");
  endtask

  task automatic test_back_to_back;
    int n;
    do_reset;
    req_data[31:16] = {8'h63, 8'h62};
    req_valid       = 4'b1100;
    sb_q.push_back({2'd2, 8'h62});
    sb_q.push_back({2'd3, 8'h63});
    sb_q.push_back({2'd2, 8'h62});
    n = 0;
    for (int i = 0; i < 300 && n < 3; i++) begin
      @(negedge clk_25mhz);
      if (req_ready !== 4'b0000) begin
        n++;
        if (n >= 2) begin
          checks++;
          if (cyc != last_done_cyc + 1 + GAP_CLKS) begin
            errors++;
            $display("[TB] FAIL t6_gap: ready %0d cycles after done, expected %0d", cyc - last_done_cyc, 1 + GAP_CLKS);
          end
        end
      end
    end
    @(posedge clk_25mhz); #1;
    req_valid = 4'b0000;
    checks++; if (n != 3) begin errors++; $display("[TB] FAIL t6_count: got %0d grants, expected 3", n); end
    drain("t6");
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_pointer_wrap;
    test_timeout;
    test_reset_midflight;
    test_back_to_back;
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("[TB] FAIL sb_leftover: got %0d pending, expected 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
